serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_sub_cell.sv | 13 +
 rtl/serial_sub.sv | 101 ++++++++++
 tb/tb_serial_sub.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// Single-bit full subtractor: diff = a - b - bin, bout set when a borrow is needed.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first, one bit per clock).
// Define SERIAL_SUB_BIN_EN to add a borrow-in port for multi-word chaining.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_init;
  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUB_BIN_EN
  assign br_init = bin;
`else
  assign br_init = 1'b0;
`endif

  full_sub_cell u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .diff (d),
    .bout (br_nxt)
  );

  // New bit enters at the MSB; after the last step this is the whole difference.
  assign res_nxt = {d, res};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= br_init;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nxt[WIDTH-1:1];
          br  <= br_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= res_nxt;
            bout  <= br_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=8).
// Define SERIAL_SUB_BIN_EN to also exercise the borrow-in port.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
`ifdef SERIAL_SUB_BIN_EN
  logic       bin;
`endif
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int checks = 0;
  int errors = 0;

  serial_sub #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUB_BIN_EN
    .bin   (bin),
`endif
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle and wait (bounded) for done; no comparisons here.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        output logic [7:0] rd, output logic rb,
                        output int lat, output int bcnt, output bit to);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    to   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    rd = diff;
    rb = bout;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b diff=%h bout=%b required 0 0 00 0",
               busy, done, diff, bout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    logic [7:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
    logic [7:0] vb [4] = '{8'h03, 8'h05, 8'h01, 8'hFF};
    logic [7:0] ed [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
    logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] rd;
    logic       rb;
    int         lat, bcnt;
    bit         to;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], rd, rb, lat, bcnt, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL basic_timeout vec=%0d no done within 20 cycles", i);
        continue;
      end
      checks++;
      if (rd !== ed[i] || rb !== eb[i]) begin
        errors++;
        $display("FAIL basic_result %h-%h diff=%h bout=%b required diff=%h bout=%b",
                 va[i], vb[i], rd, rb, ed[i], eb[i]);
      end
      checks++;
      if (lat != 9 || bcnt != 8) begin
        errors++;
        $display("FAIL basic_timing vec=%0d latency=%0d busy_cycles=%0d required 9 8",
                 i, lat, bcnt);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || diff !== ed[i]) begin
        errors++;
        $display("FAIL basic_hold vec=%0d done=%b diff=%h required 0 %h",
                 i, done, diff, ed[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 300;
    logic [7:0] ea, eb_v, prev;
    int gap;
    @(negedge clk);
    a = 8'h00; b = 8'h00; start = 1'b1;
    @(negedge clk);
    prev = 8'h00;
    for (int i = 0; i < N; i++) begin
      ea   = (i == 0) ? 8'h00 : 8'(i * 73 + 11);
      eb_v = (i == 0) ? 8'h00 : 8'(i * 151 + 5);
      if (i == N - 1) begin
        a = 8'hFF; b = 8'h00;
      end else begin
        a = 8'(i * 73 + 84);
        b = 8'(i * 151 + 156);
      end
      gap = 1;
      while (!done && gap < 20) begin
        @(negedge clk);
        gap++;
        if (gap == 4 && i > 0) begin
          checks++;
          if (diff !== prev) begin
            errors++;
            $display("FAIL b2b_hold op=%0d diff=%h required %h", i, diff, prev);
          end
        end
      end
      checks++;
      if (!done || gap != 9) begin
        errors++;
        $display("FAIL b2b_period op=%0d done=%b cycles=%0d required 1 9", i, done, gap);
      end
      checks++;
      if (diff !== 8'(ea - eb_v) || bout !== (ea < eb_v)) begin
        errors++;
        $display("FAIL b2b_result %h-%h diff=%h bout=%b required diff=%h bout=%b",
                 ea, eb_v, diff, bout, 8'(ea - eb_v), ea < eb_v);
      end
      prev = 8'(ea - eb_v);
      if (i == N - 1) start = 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 1 && i <= 4) begin
        start = i[0];
        a = 8'h55 + 8'(i);
        b = 8'hAA - 8'(i);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        checks++;
        if (diff !== 8'h0F || bout !== 1'b0) begin
          errors++;
          $display("FAIL ignore_result diff=%h bout=%b required 0f 0", diff, bout);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d required 1", ndone);
    end
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    logic [7:0] rd;
    logic       rb;
    int         lat, bcnt;
    bit         to;
    @(negedge clk);
    a = 8'h33; b = 8'h44; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear busy=%b done=%b diff=%h bout=%b required 0 0 00 0",
               busy, done, diff, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midreset_activity busy/done seen %0d cycles required 0", ndone);
    end
    run_op(8'h42, 8'h17, rd, rb, lat, bcnt, to);
    checks++;
    if (to || rd !== 8'h2B || rb !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next timeout=%b diff=%h bout=%b required 0 2b 0", to, rd, rb);
    end
  endtask

`ifdef SERIAL_SUB_BIN_EN
  task automatic test_bin;
    logic [7:0] rd;
    logic       rb;
    int         lat, bcnt;
    bit         to;
    bin = 1'b1;
    run_op(8'h05, 8'h03, rd, rb, lat, bcnt, to);
    checks++;
    if (to || rd !== 8'h01 || rb !== 1'b0) begin
      errors++;
      $display("FAIL bin_a timeout=%b diff=%h bout=%b required 0 01 0", to, rd, rb);
    end
    run_op(8'h00, 8'h00, rd, rb, lat, bcnt, to);
    checks++;
    if (to || rd !== 8'hFF || rb !== 1'b1) begin
      errors++;
      $display("FAIL bin_b timeout=%b diff=%h bout=%b required 0 ff 1", to, rd, rb);
    end
    bin = 1'b0;
  endtask
`endif

  initial begin
`ifdef SERIAL_SUB_BIN_EN
    bin = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
`ifdef SERIAL_SUB_BIN_EN
    test_bin();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
